// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; remainder goes to HI and
// quotient to LO, with a combinational stall request covering the issue cycle.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             start_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic             we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_comb begin
        a_neg = signed_div_i & opdata1_i[WIDTH-1];
        b_neg = signed_div_i & opdata2_i[WIDTH-1];
        abs_a = a_neg ? -opdata1_i : opdata1_i;
        abs_b = b_neg ? -opdata2_i : opdata2_i;
        // One extra bit keeps the trial exact when the divisor has its MSB set.
        trial  = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
        ge     = ~trial[WIDTH];
        rem_nx = ge ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
        quo_nx = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            dvd   <= opdata1_i;
                            state <= S_BYZERO;
                        end else begin
                            dvd   <= abs_a;
                            dsr   <= abs_b;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            neg_r <= a_neg;
                            neg_q <= a_neg ^ b_neg;
                            state <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        hi_o  <= dvd;
                        lo_o  <= '1;
                        state <= S_DONE;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            hi_o  <= neg_r ? -rem_nx : rem_nx;
                            lo_o  <= neg_q ? -quo_nx : quo_nx;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = rst & ((state == S_ON) || (state == S_BYZERO) ||
                         ((state == S_IDLE) && start_i && !annul_i));
        ready_o = (state == S_DONE) && !annul_i;
        we_o    = ready_o;
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed cases with literal results plus
// randomized operations compared every cycle against a cycle-count reference model.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        busy_o;
    logic        ready_o;
    logic        we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .we_o         (we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {hi, lo}.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Cycle model: cycles left before the result cycle, plus the committed HI/LO.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (annul_i) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end
        end else if (start_i && !annul_i) begin
            {p_hi, p_lo} = ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_left = (opdata2_i == 32'd0) ? 1 : 32;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("busy",  {31'd0, busy_o},
                {31'd0, (m_left > 0) || (!m_done && m_left == 0 && start_i && !annul_i)});
            chk("ready", {31'd0, ready_o}, {31'd0, m_done && !annul_i});
            chk("we",    {31'd0, we_o},    {31'd0, m_done && !annul_i});
            chk("hi",    hi_o, m_hi);
            chk("lo",    lo_o, m_lo);
        end
    end

    // Issue one operation; cycle 0 is the issue cycle.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
        int lat;
        @(posedge clk);
        #1;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            start_i   = 1'b0;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
            if (ready_o) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("op_lo", lo_o, exp_lo);
        chk("op_hi", hi_o, exp_hi);
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a, b;
        bit          s;

        #1;
        chk("rst_busy",  {31'd0, busy_o},  32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        #22;
        rst    = 1'b1;
        chk_en = 1'b1;

        run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_op(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_op(1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // Cancel in cycle 10, with a stray start pulse earlier in ON.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            start_i = (i == 5);
            annul_i = (i == 10);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            annul_i = 1'b0;
            start_i = 1'b0;
            @(negedge clk);
            if (ready_o || we_o) begin
                chk("annul_pulse", {31'd0, ready_o}, 32'd0);
                break;
            end
        end
        chk("annul_busy", {31'd0, busy_o}, 32'd0);
        chk("annul_hi", hi_o, 32'h8000_0000);
        chk("annul_lo", lo_o, 32'd0);

        // Reset in cycle 15 of an operation.
        @(posedge clk);
        #1;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, busy_o},  32'd0);
        chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
        chk("mid_rst_we",    {31'd0, we_o},    32'd0);
        chk("mid_rst_hi", hi_o, 32'd0);
        chk("mid_rst_lo", lo_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        run_op(0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Randomized operations with corner-biased operands.
        for (int n = 0; n < 60; n++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                4: b = 32'h8000_0000;
                default: ;
            endcase
            r = ref_div(s, a, b);
            run_op(s, a, b, r[31:0], r[63:32], (b == 32'd0) ? 2 : 33);
        end

        @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
